fetch_queue: RTL and testbench

- Instruction fetch queue; the transmitter side of the ID→rename interface that blaze_core_top consumes (instr_val_id / instr_id).
- Accepts up to FETCH_WIDTH instruction words per cycle from the fetch unit and buffers them in a circular queue.
- Presents up to ISSUE_WIDTH_MAX oldest instructions per cycle, oldest in lane 0.
- Holds its output whenever dispatch is stalled by a full ROB or a full RS, and is cleared by a flush.

---
 rtl/fetch_queue_pkg.sv | 42 ++++
 rtl/fetch_queue_storage.sv | 42 ++++
 rtl/fetch_queue.sv | 148 ++++++++++++++
 tb/tb_fetch_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared constants, the per-lane fetch bundle type and a small helper for the
// instruction fetch queue.
//   FQ_DEPTH        : number of instruction entries (power of two)
//   FETCH_WIDTH     : instructions accepted per cycle
//   ISSUE_WIDTH_MAX : instructions presented per cycle
//   DATA_LEN        : instruction word width
//   FQ_PTR_LEN      : head/tail pointer width
//   FQ_CNT_LEN      : occupancy counter width (one extra bit so that full and
//                     empty are distinguishable)
// ----------------------------------------------------------------------------
package fetch_queue_pkg;

   localparam int FQ_DEPTH        = 8;
   localparam int FETCH_WIDTH     = 2;
   localparam int ISSUE_WIDTH_MAX = 2;
   localparam int DATA_LEN        = 32;
   localparam int FQ_PTR_LEN      = $clog2(FQ_DEPTH);
   localparam int FQ_CNT_LEN      = FQ_PTR_LEN + 1;

   // One write lane into storage: v doubles as the write enable
   typedef struct packed {
      logic                v;
      logic [DATA_LEN-1:0] instr;
   } fetch_bundle_t;

   // Keeps only the contiguous run of set bits starting at lane 0, so a
   // malformed bundle such as 2'b10 contributes nothing
   function automatic logic [FETCH_WIDTH-1:0] prefix_mask(input logic [FETCH_WIDTH-1:0] val);
      logic                   run;
      logic [FETCH_WIDTH-1:0] mask;
      run  = 1'b1;
      mask = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         run     = run & val[i];
         mask[i] = run;
      end
      return mask;
   endfunction

endpackage

// File: rtl/fetch_queue_storage.sv
// ----------------------------------------------------------------------------
// fq_storage
// Circular instruction array with FETCH_WIDTH write ports and ISSUE_WIDTH_MAX
// read ports. Addresses wrap modulo FQ_DEPTH. Contents are not reset.
// Ports:
//   clk       : core clock
//   wr_ptr    : slot written by write lane 0; lane j writes wr_ptr+j
//   wr_bundle : per-lane write enable and data (valid lanes form a low prefix)
//   rd_ptr    : slot read by read lane 0; lane i reads rd_ptr+i
//   rd_data   : read lanes packed, lane 0 in the low bits
// ----------------------------------------------------------------------------
module fq_storage
   import fetch_queue_pkg::*;
(
   input  logic                                clk,
   input  logic [FQ_PTR_LEN-1:0]               wr_ptr,
   input  fetch_bundle_t [FETCH_WIDTH-1:0]     wr_bundle,
   input  logic [FQ_PTR_LEN-1:0]               rd_ptr,
   output logic [ISSUE_WIDTH_MAX*DATA_LEN-1:0] rd_data
);

   logic [DATA_LEN-1:0] mem [FQ_DEPTH];

   // Write lanes land in consecutive slots; pointer addition wraps naturally
   // because the pointer width is exactly log2 of the depth
   always_ff @(posedge clk) begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
         if (wr_bundle[j].v) begin
            mem[wr_ptr + FQ_PTR_LEN'(j)] <= wr_bundle[j].instr;
         end
      end
   end

   // Read lanes are unconditional; the queue masks lanes beyond occupancy
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
         rd_data[i*DATA_LEN +: DATA_LEN] = mem[rd_ptr + FQ_PTR_LEN'(i)];
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Instruction fetch queue feeding the ID->rename interface. Buffers up to
// FETCH_WIDTH fetched words per cycle and presents the ISSUE_WIDTH_MAX oldest,
// oldest in lane 0. Output holds while the ROB or RS is full; flush empties it.
// Optional build macro: FQ_BYPASS_EN (empty-queue same-cycle bypass).
// Ports:
//   clk          : core clock, rising edge
//   rst          : asynchronous active-low reset
//   fetch_val    : per-lane fetch valid (expected low-contiguous)
//   fetch_instr  : fetched words, lane 0 in the low bits
//   fetch_rdy    : room for a full FETCH_WIDTH bundle (registered count only)
//   flush        : discard all entries
//   rob_full     : dispatch stall from the ROB
//   rs_full      : dispatch stall from the RS
//   instr_val_id : per-lane output valid, low-contiguous
//   instr_id     : output words, lane 0 oldest; invalid lanes driven 0
//   fq_count     : current occupancy
//   fq_err       : sticky flag for a non-contiguous fetch_val while ready
// ----------------------------------------------------------------------------
module fetch_queue
   import fetch_queue_pkg::*;
(
   input  logic                                clk,
   input  logic                                rst,
   input  logic [FETCH_WIDTH-1:0]              fetch_val,
   input  logic [FETCH_WIDTH*DATA_LEN-1:0]     fetch_instr,
   output logic                                fetch_rdy,
   input  logic                                flush,
   input  logic                                rob_full,
   input  logic                                rs_full,
   output logic [ISSUE_WIDTH_MAX-1:0]          instr_val_id,
   output logic [ISSUE_WIDTH_MAX*DATA_LEN-1:0] instr_id,
   output logic [FQ_CNT_LEN-1:0]               fq_count,
   output logic                                fq_err
);

   logic [FQ_PTR_LEN-1:0]               head_q, tail_q;
   logic [FQ_CNT_LEN-1:0]               count_q;
   logic                                err_q;
   logic                                stall, do_push, bypass;
   logic [FETCH_WIDTH-1:0]              push_mask;
   logic [FQ_CNT_LEN-1:0]               push_n, pop_n, byp_n, wr_n;
   fetch_bundle_t [FETCH_WIDTH-1:0]     wr_bundle;
   logic [ISSUE_WIDTH_MAX*DATA_LEN-1:0] rd_data;

   assign stall     = rob_full | rs_full;
   assign fetch_rdy = (count_q <= FQ_CNT_LEN'(FQ_DEPTH - FETCH_WIDTH));
   assign push_mask = prefix_mask(fetch_val);
   assign do_push   = fetch_rdy && (|push_mask) && !flush;
   assign fq_count  = count_q;
   assign fq_err    = err_q;

`ifdef FQ_BYPASS_EN
   assign bypass = (count_q == '0) && !stall && !flush;
`else
   assign bypass = 1'b0;
`endif

   // Push size is the contiguous prefix only; pop takes every presented lane
   // or nothing, so it is simply min(count, ISSUE_WIDTH_MAX) when not stalled.
   // Bypassed lanes go straight to the output and are never written.
   always_comb begin
      push_n = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (push_mask[i]) begin
            push_n = push_n + FQ_CNT_LEN'(1);
         end
      end
      pop_n = '0;
      if (!stall && !flush) begin
         pop_n = (count_q > FQ_CNT_LEN'(ISSUE_WIDTH_MAX)) ? FQ_CNT_LEN'(ISSUE_WIDTH_MAX) : count_q;
      end
      byp_n = '0;
      if (bypass && do_push) begin
         byp_n = (push_n > FQ_CNT_LEN'(ISSUE_WIDTH_MAX)) ? FQ_CNT_LEN'(ISSUE_WIDTH_MAX) : push_n;
      end
      wr_n = do_push ? (push_n - byp_n) : '0;
   end

   // Shift the fetch lanes down past any bypassed ones so storage always
   // writes a low prefix starting at tail
   always_comb begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
         wr_bundle[j] = '0;
         for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (k == j + int'(byp_n)) begin
               wr_bundle[j].v     = do_push & push_mask[k];
               wr_bundle[j].instr = fetch_instr[k*DATA_LEN +: DATA_LEN];
            end
         end
      end
   end

   fq_storage u_storage (
      .clk       (clk),
      .wr_ptr    (tail_q),
      .wr_bundle (wr_bundle),
      .rd_ptr    (head_q),
      .rd_data   (rd_data)
   );

   // Output lanes come from registered state; with bypass active the queue
   // is empty, so the incoming prefix takes over the low lanes
   always_comb begin
      instr_val_id = '0;
      instr_id     = '0;
      for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
         if (FQ_CNT_LEN'(i) < count_q) begin
            instr_val_id[i]                  = 1'b1;
            instr_id[i*DATA_LEN +: DATA_LEN] = rd_data[i*DATA_LEN +: DATA_LEN];
         end
      end
      for (int i = 0; i < ISSUE_WIDTH_MAX && i < FETCH_WIDTH; i++) begin
         if (FQ_CNT_LEN'(i) < byp_n) begin
            instr_val_id[i]                  = 1'b1;
            instr_id[i*DATA_LEN +: DATA_LEN] = fetch_instr[i*DATA_LEN +: DATA_LEN];
         end
      end
   end

   // Pointers and occupancy; flush wins over any push or pop in that cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_q + FQ_PTR_LEN'(pop_n);
         tail_q  <= tail_q + FQ_PTR_LEN'(wr_n);
         count_q <= count_q + wr_n - pop_n;
      end
   end

   // Protocol error is sticky until reset; only judged while the queue listens
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (fetch_rdy && (fetch_val != push_mask)) begin
         err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
// Directed self-checking bench for fetch_queue (default build, no bypass).
// Inputs change #1 after the rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_fetch_queue;

   logic        clk;
   logic        rst;
   logic [1:0]  fetch_val;
   logic [63:0] fetch_instr;
   logic        fetch_rdy;
   logic        flush;
   logic        rob_full;
   logic        rs_full;
   logic [1:0]  instr_val_id;
   logic [63:0] instr_id;
   logic [3:0]  fq_count;
   logic        fq_err;

   int checks = 0;
   int errors = 0;

   fetch_queue dut (
      .clk          (clk),
      .rst          (rst),
      .fetch_val    (fetch_val),
      .fetch_instr  (fetch_instr),
      .fetch_rdy    (fetch_rdy),
      .flush        (flush),
      .rob_full     (rob_full),
      .rs_full      (rs_full),
      .instr_val_id (instr_val_id),
      .instr_id     (instr_id),
      .fq_count     (fq_count),
      .fq_err       (fq_err)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every comparison goes through here
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] val, input logic [31:0] i0, input logic [31:0] i1,
                                input logic rob, input logic rs, input logic fl);
      fetch_val   = val;
      fetch_instr = {i1, i0};
      rob_full    = rob;
      rs_full     = rs;
      flush       = fl;
   endtask

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pushed;
      int expn;
      logic stall;

      rst = 1'b0;
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      #2;
      checkOutput("reset_count", fq_count, 0);
      checkOutput("reset_val", instr_val_id, 0);
      checkOutput("reset_err", fq_err, 0);
      #5 rst = 1'b1;
      waitCycle();
      checkOutput("reset_rdy", fetch_rdy, 1);

      // Basic flow
      applyStimulus(2'b11, 32'h00000013, 32'h00100093, 1'b0, 1'b0, 1'b0);
      waitCycle();
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("basic_val", instr_val_id, 2'b11);
      checkOutput("basic_id0", instr_id[31:0], 32'h00000013);
      checkOutput("basic_id1", instr_id[63:32], 32'h00100093);
      checkOutput("basic_cnt2", fq_count, 2);
      waitCycle();
      checkOutput("basic_cnt0", fq_count, 0);
      checkOutput("basic_val0", instr_val_id, 2'b00);

      // Fill to full under ROB stall
      for (int b = 0; b < 4; b++) begin
         applyStimulus(2'b11, 32'hA0 + 2*b, 32'hA1 + 2*b, 1'b1, 1'b0, 1'b0);
         waitCycle();
      end
      checkOutput("full_cnt", fq_count, 8);
      checkOutput("full_rdy", fetch_rdy, 0);
      checkOutput("full_id0", instr_id[31:0], 32'hA0);
      applyStimulus(2'b11, 32'hEE, 32'hEF, 1'b1, 1'b0, 1'b0);
      waitCycle();
      checkOutput("full_ignore_cnt", fq_count, 8);
      checkOutput("full_stable_id0", instr_id[31:0], 32'hA0);
      checkOutput("full_stable_id1", instr_id[63:32], 32'hA1);
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      for (int b = 0; b < 4; b++) begin
         checkOutput("drain_val", instr_val_id, 2'b11);
         checkOutput("drain_id0", instr_id[31:0], 32'hA0 + 2*b);
         checkOutput("drain_id1", instr_id[63:32], 32'hA1 + 2*b);
         waitCycle();
      end
      checkOutput("drain_cnt", fq_count, 0);
      checkOutput("drain_val0", instr_val_id, 2'b00);

      // Wrap-around: singles 1..20 with periodic stalls, scoreboarded in order
      pushed = 1;
      expn   = 1;
      for (int cyc = 0; cyc < 200 && expn <= 20; cyc++) begin
         stall = (cyc % 3 == 2);
         if (pushed <= 20 && fetch_rdy) begin
            applyStimulus(2'b01, pushed, 32'h0, 1'b0, stall, 1'b0);
            pushed++;
         end else begin
            applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, stall, 1'b0);
         end
         if (!stall) begin
            if (instr_val_id[0]) begin
               checkOutput("wrap_lane0", instr_id[31:0], expn);
               expn++;
            end
            if (instr_val_id[1]) begin
               checkOutput("wrap_lane1", instr_id[63:32], expn);
               expn++;
            end
         end
         waitCycle();
      end
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("wrap_all_seen", expn, 21);
      checkOutput("wrap_empty", fq_count, 0);

      // Simultaneous push and pop at count 6
      for (int b = 0; b < 3; b++) begin
         applyStimulus(2'b11, 32'hB0 + 2*b, 32'hB1 + 2*b, 1'b1, 1'b0, 1'b0);
         waitCycle();
      end
      checkOutput("pp_cnt6", fq_count, 6);
      checkOutput("pp_rdy", fetch_rdy, 1);
      applyStimulus(2'b11, 32'hB6, 32'hB7, 1'b0, 1'b0, 1'b0);
      checkOutput("pp_id0_pre", instr_id[31:0], 32'hB0);
      waitCycle();
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("pp_cnt_after", fq_count, 6);
      for (int b = 1; b < 4; b++) begin
         checkOutput("pp_id0", instr_id[31:0], 32'hB0 + 2*b);
         checkOutput("pp_id1", instr_id[63:32], 32'hB1 + 2*b);
         waitCycle();
      end
      checkOutput("pp_empty", fq_count, 0);

      // Flush mid-stream with a simultaneous push
      applyStimulus(2'b11, 32'hC0, 32'hC1, 1'b0, 1'b1, 1'b0);
      waitCycle();
      applyStimulus(2'b11, 32'hC2, 32'hC3, 1'b0, 1'b1, 1'b0);
      waitCycle();
      applyStimulus(2'b01, 32'hC4, 32'h0, 1'b0, 1'b1, 1'b0);
      waitCycle();
      checkOutput("flush_pre_cnt", fq_count, 5);
      applyStimulus(2'b11, 32'hD0, 32'hD1, 1'b0, 1'b1, 1'b1);
      waitCycle();
      checkOutput("flush_cnt", fq_count, 0);
      checkOutput("flush_val", instr_val_id, 2'b00);
      checkOutput("flush_rdy", fetch_rdy, 1);
      applyStimulus(2'b11, 32'hE0, 32'hE1, 1'b0, 1'b0, 1'b0);
      waitCycle();
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("post_flush_cnt", fq_count, 2);
      checkOutput("post_flush_id0", instr_id[31:0], 32'hE0);
      checkOutput("post_flush_id1", instr_id[63:32], 32'hE1);
      waitCycle();

      // Asynchronous reset between edges, then a malformed bundle
      applyStimulus(2'b11, 32'hF0, 32'hF1, 1'b0, 1'b1, 1'b0);
      waitCycle();
      applyStimulus(2'b01, 32'hF2, 32'h0, 1'b0, 1'b1, 1'b0);
      waitCycle();
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      checkOutput("areset_pre_cnt", fq_count, 3);
      #2 rst = 1'b0;
      #1;
      checkOutput("areset_cnt", fq_count, 0);
      checkOutput("areset_val", instr_val_id, 2'b00);
      #2 rst = 1'b1;
      waitCycle();
      checkOutput("areset_err0", fq_err, 0);
      applyStimulus(2'b10, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0);
      waitCycle();
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("err_set", fq_err, 1);
      checkOutput("err_no_push", fq_count, 0);
      waitCycle();
      checkOutput("err_sticky", fq_err, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
